// File: rtl/frame_capture_gate.sv
// Frame capture gate: turns a free-running vsync/de/RGB stream into one cropped,
// frame-aligned frame per start request for the downstream resizer.
module frame_capture_gate #(
    parameter int SRC_W  = 1280,
    parameter int SRC_H  = 720,
    parameter int CROP_X = 280,
    parameter int CROP_W = 720,
    parameter int CROP_Y = 0,
    parameter int CROP_H = 720
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        start,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [23:0] i_data,
    output logic        o_de,
    output logic [23:0] o_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_frame_err
);

    localparam int CW = $clog2(SRC_W + 1);
    localparam int RW = $clog2(SRC_H + 1);

    localparam logic [CW-1:0] COL_MAX  = CW'(SRC_W);
    localparam logic [CW-1:0] COL_X    = CW'(CROP_X);
    localparam logic [CW-1:0] COL_N    = CW'(CROP_W);
    localparam logic [RW-1:0] ROW_Y    = RW'(CROP_Y);
    localparam logic [RW-1:0] ROW_N    = RW'(CROP_H);
    localparam logic [RW-1:0] ROW_LAST = RW'(SRC_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          vs_dly_q, de_dly_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          err_q, err_d;
    logic          ode_q, ode_d;
    logic [23:0]   odata_q, odata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;

    logic          vs_rise, de_fall, in_window, line_bad;
    logic [CW-1:0] col_off;
    logic [RW-1:0] row_off;

    assign vs_rise  = i_vs & ~vs_dly_q;
    assign de_fall  = ~i_de & de_dly_q;
    assign line_bad = (col_q != COL_MAX);

    // Offsets wrap to values above the window size when below the crop origin,
    // so one unsigned compare per axis covers both window bounds.
    assign col_off   = col_q - COL_X;
    assign row_off   = row_q - ROW_Y;
    assign in_window = (col_off < COL_N) && (row_off < ROW_N);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        err_d   = err_q;
        ode_d   = 1'b0;
        odata_d = odata_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ARM;
            end
            S_ARM: begin
                if (vs_rise) begin
                    state_d = S_CAPTURE;
                    col_d   = '0;
                    row_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (vs_rise) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    ferr_d  = 1'b1;
                end else if (i_de) begin
                    if (in_window) begin
                        ode_d   = 1'b1;
                        odata_d = i_data;
                    end
                    if (line_bad) col_d = col_q + CW'(1);
                end else if (de_fall) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                    if (line_bad) err_d = 1'b1;
                    if (row_q == ROW_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        ferr_d  = err_q | line_bad;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_ARM) || (state_d == S_CAPTURE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            vs_dly_q <= 1'b0;
            de_dly_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            err_q    <= 1'b0;
            ode_q    <= 1'b0;
            odata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_dly_q <= i_vs;
            de_dly_q <= i_de;
            col_q    <= col_d;
            row_q    <= row_d;
            err_q    <= err_d;
            ode_q    <= ode_d;
            odata_q  <= odata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
        end
    end

    assign o_de        = ode_q;
    assign o_data      = odata_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_frame_err = ferr_q;

endmodule
